clarvi_writeback: RTL and testbench

Writeback stage of the Clarvi RV64 core, directly upstream of the register file: it merges single-cycle execute results with in-order, unstallable memory load responses into the register file's single write port. It tracks outstanding loads in a small queue, aligns and sign/zero-extends returned load data, buffers execute results while a load response takes the port, and exports a pending-destination mask for hazard stalls in decode.

---
 rtl/clarvi_writeback_pkg.sv | 33 +++
 rtl/clarvi_load_align.sv | 36 +++
 rtl/clarvi_writeback.sv | 143 ++++++++++++++
 tb/tb_clarvi_writeback.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clarvi_writeback_pkg.sv
// Shared writeback types: load funct3 encoding, register index and queue entries.
// Imported by clarvi_writeback and clarvi_load_align.
package clarvi_writeback_pkg;

   typedef logic [4:0] reg_idx_t;

   typedef enum logic [2:0] {
      F3_LB   = 3'b000,
      F3_LH   = 3'b001,
      F3_LW   = 3'b010,
      F3_LD   = 3'b011,
      F3_LBU  = 3'b100,
      F3_LHU  = 3'b101,
      F3_LWU  = 3'b110,
      F3_NONE = 3'b111
   } load_funct3_t;

   typedef struct packed {
      reg_idx_t     rd;
      load_funct3_t funct3;
      logic [2:0]   offset;
   } ldq_entry_t;

   typedef struct packed {
      reg_idx_t    rd;
      logic [63:0] data;
   } ex_entry_t;

   function automatic logic [31:0] rd_onehot(reg_idx_t r);
      return 32'd1 << r;
   endfunction

endpackage

// File: rtl/clarvi_load_align.sv
// Load data alignment: picks the addressed lane out of the doubleword and
// sign/zero-extends it according to the load type.
module clarvi_load_align
   import clarvi_writeback_pkg::*;
(
   input  load_funct3_t funct3,
   input  logic [2:0]   offset,
   input  logic [63:0]  rdata,
   output logic [63:0]  data
);

   logic [2:0]  off;
   logic [63:0] lane;

   always_comb begin
      // low address bits below the access size are ignored
      unique case (funct3[1:0])
         2'b00:   off = offset;
         2'b01:   off = {offset[2:1], 1'b0};
         2'b10:   off = {offset[2], 2'b00};
         default: off = 3'b000;
      endcase
      lane = rdata >> {off, 3'b000};
      unique case (funct3)
         F3_LB:   data = {{56{lane[7]}}, lane[7:0]};
         F3_LH:   data = {{48{lane[15]}}, lane[15:0]};
         F3_LW:   data = {{32{lane[31]}}, lane[31:0]};
         F3_LD:   data = lane;
         F3_LBU:  data = {56'd0, lane[7:0]};
         F3_LHU:  data = {48'd0, lane[15:0]};
         F3_LWU:  data = {32'd0, lane[31:0]};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/clarvi_writeback.sv
// Writeback stage: merges execute results and load responses onto one port.
// CLARVI_WB_BYPASS_EN: empty-FIFO execute results skip the FIFO (1-cycle latency).
module clarvi_writeback
   import clarvi_writeback_pkg::*;
#(
   parameter int EX_FIFO_DEPTH = 2,
   parameter int LDQ_DEPTH     = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [4:0]  ex_rd,
   input  logic [63:0] ex_data,
   input  logic        ld_issue,
   output logic        ld_issue_ready,
   input  logic [4:0]  ld_rd,
   input  logic [2:0]  ld_funct3,
   input  logic [2:0]  ld_offset,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata,
   output logic [4:0]  write_register,
   output logic [63:0] data_in,
   output logic        write_enable,
   output logic [31:0] rd_busy
);

   localparam int EW = $clog2(EX_FIFO_DEPTH);
   localparam int LW = $clog2(LDQ_DEPTH);
   localparam logic [EW:0] EX_FULL = (EW+1)'(EX_FIFO_DEPTH);
   localparam logic [LW:0] LD_FULL = (LW+1)'(LDQ_DEPTH);

   ldq_entry_t    ldq [LDQ_DEPTH];
   logic [LW-1:0] ldq_head;
   logic [LW-1:0] ldq_tail;
   logic [LW:0]   ldq_cnt;

   ex_entry_t     exf [EX_FIFO_DEPTH];
   logic [EW-1:0] exf_head;
   logic [EW-1:0] exf_tail;
   logic [EW:0]   exf_cnt;

   logic        ex_acc;
   logic        ld_push;
   logic        ld_pop;
   logic        exf_push;
   logic        exf_pop;
   logic        bypass;
   logic        sel_valid;
   reg_idx_t    sel_rd;
   logic [63:0] sel_data;
   logic [63:0] ld_data;
   ldq_entry_t  ld_head;

   assign ex_ready       = exf_cnt != EX_FULL;
   assign ld_issue_ready = ldq_cnt != LD_FULL;
   assign ld_head        = ldq[ldq_head];

   clarvi_load_align u_align (
      .funct3 (ld_head.funct3),
      .offset (ld_head.offset),
      .rdata  (mem_rdata),
      .data   (ld_data)
   );

   always_comb begin
      ex_acc  = ex_valid && ex_ready;
      ld_push = ld_issue && ld_issue_ready;
      // a response with nothing queued is spurious and dropped
      ld_pop  = mem_rvalid && (ldq_cnt != '0);
      exf_pop = !ld_pop && (exf_cnt != '0);
`ifdef CLARVI_WB_BYPASS_EN
      bypass  = !ld_pop && (exf_cnt == '0) && ex_acc;
`else
      bypass  = 1'b0;
`endif
      exf_push  = ex_acc && !bypass;
      sel_valid = 1'b0;
      sel_rd    = '0;
      sel_data  = '0;
      unique case (1'b1)
         ld_pop: begin
            sel_valid = 1'b1;
            sel_rd    = ld_head.rd;
            sel_data  = ld_data;
         end
         exf_pop: begin
            sel_valid = 1'b1;
            sel_rd    = exf[exf_head].rd;
            sel_data  = exf[exf_head].data;
         end
         bypass: begin
            sel_valid = 1'b1;
            sel_rd    = ex_rd;
            sel_data  = ex_data;
         end
         default: ;
      endcase
   end

   always_comb begin
      rd_busy = '0;
      for (int k = 0; k < LDQ_DEPTH; k++) begin
         if (k < int'(ldq_cnt))
            rd_busy = rd_busy | rd_onehot(ldq[ldq_head + LW'(k)].rd);
      end
      rd_busy[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (ld_push)
         ldq[ldq_tail] <= '{rd: ld_rd,
                            funct3: load_funct3_t'(ld_funct3),
                            offset: ld_offset};
      if (exf_push)
         exf[exf_tail] <= '{rd: ex_rd, data: ex_data};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ldq_head       <= '0;
         ldq_tail       <= '0;
         ldq_cnt        <= '0;
         exf_head       <= '0;
         exf_tail       <= '0;
         exf_cnt        <= '0;
         write_enable   <= 1'b0;
         write_register <= '0;
         data_in        <= '0;
      end else begin
         if (ld_push) ldq_tail <= ldq_tail + LW'(1);
         if (ld_pop)  ldq_head <= ldq_head + LW'(1);
         ldq_cnt <= ldq_cnt + (LW+1)'(ld_push) - (LW+1)'(ld_pop);
         if (exf_push) exf_tail <= exf_tail + EW'(1);
         if (exf_pop)  exf_head <= exf_head + EW'(1);
         exf_cnt <= exf_cnt + (EW+1)'(exf_push) - (EW+1)'(exf_pop);
         write_enable   <= sel_valid && (sel_rd != '0);
         write_register <= sel_rd;
         data_in        <= sel_data;
      end
   end

endmodule

// File: tb/tb_clarvi_writeback.sv
// Randomized scoreboard bench for clarvi_writeback against a queue-level model.
module tb_clarvi_writeback;

   localparam int EXD = 2;
   localparam int LDD = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [4:0]  ex_rd = '0;
   logic [63:0] ex_data = '0;
   logic        ld_issue = 1'b0;
   logic        ld_issue_ready;
   logic [4:0]  ld_rd = '0;
   logic [2:0]  ld_funct3 = '0;
   logic [2:0]  ld_offset = '0;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;
   logic [4:0]  write_register;
   logic [63:0] data_in;
   logic        write_enable;
   logic [31:0] rd_busy;

   typedef struct { int cyc; logic [4:0] rd; logic [63:0] data; } wr_t;
   typedef struct { logic [4:0] rd; logic [2:0] f3; logic [2:0] off; } ld_t;
   typedef struct { logic [4:0] rd; logic [63:0] data; } ex_t;

   wr_t sb[$];
   ld_t ldq[$];
   ex_t exq[$];
   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   wr_t mon_e;
   bit  dummy;

   clarvi_writeback #(.EX_FIFO_DEPTH(EXD), .LDQ_DEPTH(LDD)) dut (
      .clock(clock), .reset_n(reset_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_rd(ex_rd), .ex_data(ex_data),
      .ld_issue(ld_issue), .ld_issue_ready(ld_issue_ready),
      .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_offset(ld_offset),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .write_register(write_register), .data_in(data_in),
      .write_enable(write_enable), .rd_busy(rd_busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Loaded value from size/sign rules: bytes = 2^funct3[1:0], bit 2 = unsigned.
   function automatic logic [63:0] load_val(logic [2:0] f3, logic [2:0] off,
                                            logic [63:0] d);
      int nb;
      int a;
      logic [63:0] v;
      logic [63:0] m;
      if (f3 == 3'd7) return 64'd0;
      nb = 1 << f3[1:0];
      a  = int'(off) - (int'(off) % nb);
      v  = d >> (8 * a);
      if (nb < 8) begin
         m = (64'd1 << (8 * nb)) - 64'd1;
         v = v & m;
         if (!f3[2] && v[8*nb-1]) v = v | ~m;
      end
      return v;
   endfunction

   task automatic push_wr(input logic [4:0] rd, input logic [63:0] d);
      if (rd != 5'd0) sb.push_back('{cyc + 1, rd, d});
   endtask

   task automatic step(input bit ev, input logic [4:0] erd,
                       input logic [63:0] ed, input bit li,
                       input logic [4:0] lrd, input logic [2:0] f3,
                       input logic [2:0] off, input bit rv,
                       input logic [63:0] rdata, output bit acc);
      logic [31:0] busy;
      bit used;
      ld_t l;
      ex_t e;
      @(negedge clock);
      #1;
      busy = '0;
      foreach (ldq[i]) busy[ldq[i].rd] = 1'b1;
      busy[0] = 1'b0;
      chk("rd_busy", 64'(rd_busy), 64'(busy));
      chk("ex_ready", 64'(ex_ready), 64'(exq.size() < EXD));
      chk("ld_issue_ready", 64'(ld_issue_ready), 64'(ldq.size() < LDD));
      li  = li && (ldq.size() < LDD);
      acc = ev && (exq.size() < EXD);
      used = 1'b0;
      if (rv && ldq.size() > 0) begin
         l = ldq.pop_front();
         push_wr(l.rd, load_val(l.f3, l.off, rdata));
      end else if (exq.size() > 0) begin
         e = exq.pop_front();
         push_wr(e.rd, e.data);
      end
`ifdef CLARVI_WB_BYPASS_EN
      else if (acc) begin
         push_wr(erd, ed);
         used = 1'b1;
      end
`endif
      if (acc && !used) exq.push_back('{erd, ed});
      if (li) ldq.push_back('{lrd, f3, off});
      ex_valid   = ev;
      ex_rd      = erd;
      ex_data    = ed;
      ld_issue   = li;
      ld_rd      = lrd;
      ld_funct3  = f3;
      ld_offset  = off;
      mem_rvalid = rv;
      mem_rdata  = rdata;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, dummy);
   endtask

   task automatic ld(input logic [4:0] rd, input logic [2:0] f3,
                     input logic [2:0] off);
      step(0, 0, 0, 1, rd, f3, off, 0, 0, dummy);
   endtask

   task automatic resp(input logic [63:0] d);
      step(0, 0, 0, 0, 0, 0, 0, 1, d, dummy);
   endtask

   task automatic reset_chk();
      chk("rst_write_enable", 64'(write_enable), 64'd0);
      chk("rst_write_register", 64'(write_register), 64'd0);
      chk("rst_data_in", data_in, 64'd0);
      chk("rst_rd_busy", 64'(rd_busy), 64'd0);
      chk("rst_ex_ready", 64'(ex_ready), 64'd1);
      chk("rst_ld_issue_ready", 64'(ld_issue_ready), 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clock);
      #1;
      reset_n    = 1'b0;
      ex_valid   = 1'b0;
      ld_issue   = 1'b0;
      mem_rvalid = 1'b0;
      #1;
      reset_chk();
      sb.delete();
      ldq.delete();
      exq.delete();
      @(negedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   always @(negedge clock) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         total++;
         bad++;
         $display("FAIL missing_write: got none expected x%0d=%h at cycle %0d",
                  sb[0].rd, sb[0].data, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (reset_n && write_enable) begin
         total++;
         if (sb.size() == 0 || sb[0].cyc != cyc) begin
            bad++;
            $display("FAIL unexpected_write: got x%0d=%h expected none (cycle %0d)",
                     write_register, data_in, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.rd !== write_register || mon_e.data !== data_in) begin
               bad++;
               $display("FAIL write: got x%0d=%h expected x%0d=%h (cycle %0d)",
                        write_register, data_in, mon_e.rd, mon_e.data, cyc);
            end
         end
      end
   end

   initial begin
      bit acc;
      #1;
      reset_chk();
      @(negedge clock);
      @(negedge clock);
      #1;
      reset_n = 1'b1;

      ld(5, 3'b000, 3);
      resp(64'h0000_0000_8000_0000);
      idle(1);
      ld(7, 3'b110, 4);
      ld(8, 3'b101, 6);
      resp(64'h8765_4321_0000_0000);
      resp(64'h8765_4321_0000_0000);
      idle(2);

      ld(20, 3'b011, 0);
      ld(21, 3'b001, 3);
      step(1, 1, 64'h11, 0, 0, 0, 0, 1, 64'hFEDC_BA98_7654_3210, acc);
      step(1, 2, 64'h22, 0, 0, 0, 0, 1, 64'h0123_4567_89AB_CDEF, acc);
      for (int i = 0; i < 4; i++) begin
         step(1, 3, 64'h33, 0, 0, 0, 0, 0, 0, acc);
         if (acc) break;
      end
      idle(3);

      step(1, 0, 64'hDEAD, 0, 0, 0, 0, 0, 0, acc);
      step(1, 4, 64'h44, 0, 0, 0, 0, 0, 0, acc);
      for (int i = 0; i < 5; i++) ld(5'(10 + i), 3'b010, 3'(i));
      idle(1);
      for (int i = 0; i < 4; i++) resp(64'hF0E1_D2C3_B4A5_9687);
      resp(64'h1234);
      idle(2);

      for (int i = 0; i < 4; i++) ld(5'(24 + i), 3'b100, 3'(i));
      step(1, 9, 64'h99, 0, 0, 0, 0, 1, 64'h80, acc);
      step(1, 10, 64'hAA, 0, 0, 0, 0, 1, 64'h7F00, acc);
      do_reset();
      resp(64'h5555);
      resp(64'h6666);
      step(1, 6, 64'h66, 0, 0, 0, 0, 0, 0, acc);
      idle(3);

      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
              {$urandom, $urandom}, $urandom_range(0, 2) == 0,
              5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
              {$urandom, $urandom}, acc);
         if (i == 300) do_reset();
      end
      idle(6);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
